// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
package regfile_pkg;

  typedef enum logic {RF_CLEAR, RF_RUN} rf_state_t;

  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH  = 16;
  localparam int RF_NRD    = 3;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: sweeps every register to zero after reset or a clr request,
// then hands the array over to normal operation.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RF_CLEAR | writing 0 to register[cnt] each cycle, busy=1
// RF_RUN   | normal operation, busy=0; clr restarts the sweep at cnt=0
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  output logic          o_busy,
  output logic          o_clr_we,
  output logic [AW-1:0] o_clr_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  rf_state_t     r_state;
  logic [AW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RF_CLEAR;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        RF_CLEAR: begin
          r_cnt <= r_cnt + AW'(1);
          if (r_cnt == LAST) r_state <= RF_RUN;
        end
        default: begin
          if (i_clr) begin
            r_state <= RF_CLEAR;
            r_cnt   <= '0;
          end
        end
      endcase
    end
  end

  assign o_busy     = (r_state == RF_CLEAR);
  assign o_clr_we   = (r_state == RF_CLEAR);
  assign o_clr_addr = r_cnt;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with two prioritised write ports,
// write-to-read bypass and registered reads. Optional macro: REGFILE_ZERO_REG_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int DEPTH  = RF_DEPTH,
  parameter int NRD    = RF_NRD,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  input  logic                  we0,
  input  logic [AW-1:0]         wa0,
  input  logic [DATA_W-1:0]     wd0,
  input  logic                  we1,
  input  logic [AW-1:0]         wa1,
  input  logic [DATA_W-1:0]     wd1,
  output logic                  busy
);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic              w_busy;
  logic              w_clr_we;
  logic [AW-1:0]     w_clr_addr;
  logic              w_wr0;
  logic              w_wr1;
  logic [DATA_W-1:0] w_byp [NRD];

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd  [NRD];

  regfile_clear_seq #(.DEPTH(DEPTH)) u_clear_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (clr),
    .o_busy     (w_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  // A write is accepted only in RUN and only when clr is not pulling us back to CLEAR.
  assign w_wr0 = we0 && !w_busy && !clr && !(ZERO_REG && (wa0 == '0));
  assign w_wr1 = we1 && !w_busy && !clr && !(ZERO_REG && (wa1 == '0));

  // Storage has no reset so it can map to RAM; port 1 is written last and wins on collision.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else begin
      if (w_wr0) r_mem[wa0] <= wd0;
      if (w_wr1) r_mem[wa1] <= wd1;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] w_ra;
    assign w_ra = rd_addr[g*AW +: AW];

    always_comb begin
      w_byp[g] = r_mem[w_ra];
      if (ZERO_REG && (w_ra == '0)) w_byp[g] = '0;
      else if (w_wr1 && (wa1 == w_ra)) w_byp[g] = wd1;
      else if (w_wr0 && (wa0 == w_ra)) w_byp[g] = wd0;
    end

    assign rd_data[g*DATA_W +: DATA_W] = r_rd[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NRD; i++) r_rd[i] <= '0;
    end else begin
      for (int i = 0; i < NRD; i++) r_rd[i] <= w_busy ? '0 : w_byp[i];
    end
  end

  assign busy = w_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: vector table for RUN-mode reads/writes plus
// hand-written sequences for reset, clear and clr behaviour.
module tb_regfile_mp;

  localparam int DW  = 32;
  localparam int AWT = 4;
  localparam int NR  = 3;

`ifdef REGFILE_ZERO_REG_EN
  localparam logic [31:0] R0_EXP = 32'h0000_0000;
`else
  localparam logic [31:0] R0_EXP = 32'hCAFE_F00D;
`endif

  typedef struct {
    string                 name;
    logic                  we0;
    logic [AWT-1:0]        wa0;
    logic [DW-1:0]         wd0;
    logic                  we1;
    logic [AWT-1:0]        wa1;
    logic [DW-1:0]         wd1;
    logic [NR-1:0][AWT-1:0] ra;
    logic [NR-1:0][DW-1:0]  exp;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clr;
  logic [NR*AWT-1:0] rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic              we0, we1;
  logic [AWT-1:0]    wa0, wa1;
  logic [DW-1:0]     wd0, wd1;
  logic              busy;

  int tests  = 0;
  int errors = 0;

  regfile_mp dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .we0     (we0),
    .wa0     (wa0),
    .wd0     (wd0),
    .we1     (we1),
    .wa1     (wa1),
    .wd1     (wd1),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm,
                              input logic e0, input logic [3:0] a0, input logic [31:0] d0,
                              input logic e1, input logic [3:0] a1, input logic [31:0] d1,
                              input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2,
                              input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] x2);
    vec_t v;
    v.name = nm;
    v.we0 = e0; v.wa0 = a0; v.wd0 = d0;
    v.we1 = e1; v.wa1 = a1; v.wd1 = d1;
    v.ra[0] = r0; v.ra[1] = r1; v.ra[2] = r2;
    v.exp[0] = x0; v.exp[1] = x1; v.exp[2] = x2;
    return v;
  endfunction

  task automatic idle();
    clr = 1'b0;
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
  endtask

  // Called at a negedge; drives one cycle and checks the registered result at the next negedge.
  task automatic apply(input vec_t v);
    we0 = v.we0; wa0 = v.wa0; wd0 = v.wd0;
    we1 = v.we1; wa1 = v.wa1; wd1 = v.wd1;
    rd_addr = v.ra;
    @(posedge clk);
    @(negedge clk);
    for (int p = 0; p < NR; p++)
      check($sformatf("%s port%0d", v.name, p), rd_data[p*DW +: DW], v.exp[p]);
    check($sformatf("%s busy", v.name), {31'd0, busy}, 32'd0);
    idle();
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
  endtask

  vec_t vecs[10];
  int   n;

  initial begin
    vecs[0] = mk("clear_drop_r5", 0,0,0, 0,0,0, 5,5,5, 0,0,0);
    vecs[1] = mk("wr_r3_bypass", 1,3,32'h1234_5678, 0,0,0, 3,0,1, 32'h1234_5678,0,0);
    vecs[2] = mk("rd_r3_all", 0,0,0, 0,0,0, 3,3,3, 32'h1234_5678,32'h1234_5678,32'h1234_5678);
    vecs[3] = mk("collide_r7_byp", 1,7,32'hAAAA_0000, 1,7,32'h5555_FFFF, 7,3,7,
                 32'h5555_FFFF,32'h1234_5678,32'h5555_FFFF);
    vecs[4] = mk("rd_r7", 0,0,0, 0,0,0, 7,7,7, 32'h5555_FFFF,32'h5555_FFFF,32'h5555_FFFF);
    vecs[5] = mk("dual_wr_9_10", 1,10,32'hA0, 1,9,32'h1, 9,10,11, 32'h1,32'hA0,0);
    vecs[6] = mk("bypass_r9", 1,9,32'h2, 0,0,0, 9,10,9, 32'h2,32'hA0,32'h2);
    vecs[7] = mk("rd_9_10_15", 0,0,0, 0,0,0, 9,10,15, 32'h2,32'hA0,0);
    vecs[8] = mk("byp_prio_r11", 1,11,32'hB0, 1,11,32'hB1, 11,9,11, 32'hB1,32'h2,32'hB1);
    vecs[9] = mk("rd_r11", 0,0,0, 0,0,0, 11,11,3, 32'hB1,32'hB1,32'h1234_5678);

    idle();
    rd_addr = '0;
    rst_n = 1'b0;
    #12;
    check("reset busy", {31'd0, busy}, 32'd1);
    check("reset rd0", rd_data[0 +: DW], 32'd0);
    check("reset rd2", rd_data[2*DW +: DW], 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    rd_addr = {4'd5, 4'd5, 4'd5};
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      if (n == 8) begin
        we0 = 1'b1; wa0 = 4'd5; wd0 = 32'hDEAD_BEEF;
      end else begin
        we0 = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      n++;
      if (n == 9) check("clear rd forced 0", rd_data[0 +: DW], 32'd0);
    end
    idle();
    check("clear length", n, 32'd16);

    foreach (vecs[i]) apply(vecs[i]);

    // clr with a simultaneous write: write dropped, read still served from storage
    clr = 1'b1; we0 = 1'b1; wa0 = 4'd2; wd0 = 32'hFF;
    rd_addr = {4'd2, 4'd2, 4'd2};
    @(posedge clk);
    @(negedge clk);
    check("clr busy", {31'd0, busy}, 32'd1);
    check("clr no bypass", rd_data[0 +: DW], 32'd0);
    idle();
    rd_addr = {4'd3, 4'd3, 4'd3};
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (n == 3) check("clr rd forced 0", rd_data[0 +: DW], 32'd0);
    end
    check("clr length", n, 32'd16);
    apply(mk("after_clr", 0,0,0, 0,0,0, 2,3,7, 0,0,0));

    apply(mk("r0_wr_byp", 1,0,32'hCAFE_F00D, 0,0,0, 0,0,0, R0_EXP,R0_EXP,R0_EXP));
    apply(mk("r0_rd", 0,0,0, 0,0,0, 0,1,0, R0_EXP,0,R0_EXP));
    apply(mk("r0_wr1_byp", 0,0,0, 1,0,32'h0BAD_0BAD, 0,0,0,
             (R0_EXP == 0) ? 32'h0 : 32'h0BAD_0BAD,
             (R0_EXP == 0) ? 32'h0 : 32'h0BAD_0BAD,
             (R0_EXP == 0) ? 32'h0 : 32'h0BAD_0BAD));

    apply(mk("wr_r6", 1,6,32'h66, 0,0,0, 6,6,6, 32'h66,32'h66,32'h66));
    rd_addr = {4'd6, 4'd6, 4'd6};
    #1;
    rst_n = 1'b0;
    #1;
    check("midrun rst busy", {31'd0, busy}, 32'd1);
    check("midrun rst rd", rd_data[0 +: DW], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_busy(n);
    check("rst clear length", n, 32'd16);
    apply(mk("after_rst", 0,0,0, 0,0,0, 6,3,11, 0,0,0));

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the Decode stage; next generation of the 16-entry, 3-read/1-write register file.
- Adds configurable width, depth and read-port count, and a second write port with fixed priority.
- Adds write-to-read bypass, and a self-clearing sequencer so storage needs no per-bit reset and can map to RAM.
- Reads are registered, with one-cycle latency; all logic is on the rising edge of clk.

Parameters:
- DATA_W, 32, width of each register in bits.
- DEPTH, 16, number of registers; must be a power of two, minimum 2.
- NRD, 3, number of read ports, range 1..4.
- AW, $clog2(DEPTH), address width; localparam, not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous request to re-clear all registers.
- rd_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NRD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W].
- we0  in  1  write enable, port 0.
- wa0  in  AW  write address, port 0.
- wd0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, port 1 (higher priority).
- wa1  in  AW  write address, port 1.
- wd1  in  DATA_W  write data, port 1.
- busy  out  1  high while the clear sequence runs.

Behaviour:
- Reset is asynchronous and active-low: rst_n low forces the following immediately, independent of clk.
  - state=CLEAR, clear counter cnt=0, busy=1, all rd_data=0.
  - Storage array is NOT reset; the sequencer clears it.
- FSM has two states:
  - CLEAR: each cycle writes 0 to register[cnt], then cnt++. After the cycle with cnt==DEPTH-1, go to RUN. Clearing therefore takes exactly DEPTH cycles after rst_n rises. busy=1 throughout.
  - RUN: busy=0. clr=1 returns to CLEAR with cnt=0 on the next edge; busy is high the following cycle.
- During CLEAR:
  - we0/we1 are ignored; the writes are dropped.
  - rd_data registers load 0.
- Writes in RUN:
  - Take effect on the rising edge when the enable is high.
  - we0 and we1 both high with wa0==wa1: wd1 is stored and wd0 is discarded.
  - Different addresses: both are stored.
  - clr=1 in the same cycle as a write: clr wins and the write is dropped.
- Reads in RUN:
  - rd_data[i] updates on each rising edge from rd_addr[i] sampled at that edge. Latency is 1 cycle; there is no read enable.
  - Bypass: if a write to rd_addr[i] is accepted in the same cycle, rd_data[i] returns the new data, not the old contents.
  - Bypass priority: wd1 if we1 && wa1==rd_addr[i]; else wd0 if we0 && wa0==rd_addr[i]; else register[rd_addr[i]].
- Multiple read ports may use the same address, with no conflict.
- rd_addr and wa0/wa1 always index within 0..DEPTH-1, because DEPTH is a power of two; no out-of-range case exists.
- rst_n asserted mid-clear or mid-run aborts everything. The sequence restarts from cnt=0 after release. Register contents are undefined until CLEAR completes, and are never observable because reads return 0 during CLEAR.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired to zero.
  - Writes to address 0 on either port are discarded.
  - Reads of address 0 return 0, including the bypass path (a same-cycle write to address 0 is not forwarded).
  - Clear sequence is unchanged.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Shared package regfile_pkg:
  - typedef enum logic {RF_CLEAR, RF_RUN} rf_state_t.
  - Default constants RF_DATA_W=32, RF_DEPTH=16, RF_NRD=3.
- Sub-module regfile_clear_seq: holds the FSM, cnt and busy, and outputs the clear-write strobe and address.
- The top level holds the storage array, write arbitration, bypass muxes and read registers; one bypass mux per read port via a generate loop.

Test Plan (defaults: DATA_W=32, DEPTH=16, NRD=3):
1. Release rst_n -> busy=1 for exactly 16 cycles, then 0. A write of 0xDEADBEEF to r5 on we0 during the clear is dropped; after clear, a read of r5 returns 0x00000000.
2. RUN: write r3=0x12345678 on port 0; next cycle read r3 on all three ports -> each rd_data=0x12345678 one cycle after the address is applied.
3. Same cycle: we0 wa0=7 wd0=0xAAAA0000 and we1 wa1=7 wd1=0x5555FFFF -> subsequent read of r7 returns 0x5555FFFF.
4. Bypass: r9 holds 0x1; in one cycle write r9=0x2 on port 0 and present rd_addr0=9 -> rd_data0=0x00000002 at the next edge.
5. clr pulse in RUN with a simultaneous write of r2=0xFF -> busy=1 for 16 cycles; r2 reads 0 afterwards.
6. With REGFILE_ZERO_REG_EN: write r0=0xCAFEF00D while reading r0 in the same cycle -> rd_data=0 that cycle and on later reads. Without the macro, the same stimulus returns 0xCAFEF00D.
